regfile_write_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline write-back stage and a multi-cycle execution unit (mul/div, late loads).
- Pipeline write-back has priority.
- Multi-cycle results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation counter forces a pipeline bubble if the FIFO head waits too long.
- Exports a pending-destination mask that the hazard unit uses to stall dependent instructions.

---
 rtl/regfile_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, multi-cycle results are
// buffered in a small FIFO and drained into idle cycles, with a starvation-driven stall request.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wb_valid_i,
   input  logic [ADDR_W-1:0]      wb_rd_i,
   input  logic [DATA_W-1:0]      wb_data_i,
   input  logic                   mc_valid_i,
   output logic                   mc_ready_o,
   input  logic [ADDR_W-1:0]      mc_rd_i,
   input  logic [DATA_W-1:0]      mc_data_i,
   output logic                   rf_we_o,
   output logic [ADDR_W-1:0]      rf_rd_o,
   output logic [DATA_W-1:0]      rf_wdata_o,
   output logic                   stall_o,
   output logic [2**ADDR_W-1:0]   pending_mask_o
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned StvW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {GIdle, GWb, GMc} grant_e;

   logic [ADDR_W-1:0] rd_mem_q   [FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [StvW-1:0]   starve_q, starve_d;
   logic              stall_q, stall_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

   grant_e            grant;
   logic              push, pop;
   logic [ADDR_W-1:0] head_rd;
   logic [DATA_W-1:0] head_data;

   assign mc_ready_o = ~rst & (count_q < CntW'(FIFO_DEPTH));
   assign push       = mc_valid_i & mc_ready_o;
   assign pop        = (grant == GMc);
   assign head_rd    = rd_mem_q[rd_ptr_q];
   assign head_data  = data_mem_q[rd_ptr_q];

   always_comb begin
      grant = GIdle;
      if (wb_valid_i) begin
         grant = GWb;
      end else if (count_q != '0) begin
         grant = GMc;
      end
   end

   always_comb begin
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      starve_d   = starve_q;
      stall_d    = stall_q;

      unique case (grant)
         GWb: begin
            rf_we_d    = (wb_rd_i != '0);
            rf_rd_d    = wb_rd_i;
            rf_wdata_d = wb_data_i;
         end
         GMc: begin
            rf_we_d    = (head_rd != '0);
            rf_rd_d    = head_rd;
            rf_wdata_d = head_data;
         end
         default: rf_we_d = 1'b0;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end

      // Counter measures how long the current head has been passed over.
      if (count_q == '0 || pop) begin
         starve_d = '0;
      end else if (starve_q != StvW'(STARVE_MAX)) begin
         starve_d = starve_q + StvW'(1);
      end

      if (pop) begin
         stall_d = 1'b0;
      end else if (starve_d == StvW'(STARVE_MAX)) begin
         stall_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         stall_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         stall_q    <= stall_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Storage needs no reset: validity is carried entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= mc_rd_i;
         data_mem_q[wr_ptr_q] <= mc_data_i;
      end
   end

   always_comb begin
      logic [PtrW-1:0] offset;
      pending_mask_o = '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         offset = PtrW'(i) - rd_ptr_q;
         if ({1'b0, offset} < count_q) begin
            pending_mask_o[rd_mem_q[i]] = 1'b1;
         end
      end
      pending_mask_o[0] = 1'b0;
   end

   assign rf_we_o    = rf_we_q;
   assign rf_rd_o    = rf_rd_q;
   assign rf_wdata_o = rf_wdata_q;
   assign stall_o    = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed test-plan steps followed by random traffic, all checked against a queue-based model.
module tb_regfile_write_arbiter;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int FIFO_DEPTH = 2;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wb_valid_i = 1'b0;
   logic [ADDR_W-1:0] wb_rd_i = '0;
   logic [DATA_W-1:0] wb_data_i = '0;
   logic              mc_valid_i = 1'b0;
   logic              mc_ready_o;
   logic [ADDR_W-1:0] mc_rd_i = '0;
   logic [DATA_W-1:0] mc_data_i = '0;
   logic              rf_we_o;
   logic [ADDR_W-1:0] rf_rd_o;
   logic [DATA_W-1:0] rf_wdata_o;
   logic              stall_o;
   logic [31:0]       pending_mask_o;

   regfile_write_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o), .mc_rd_i(mc_rd_i),
      .mc_data_i(mc_data_i),
      .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o),
      .stall_o(stall_o), .pending_mask_o(pending_mask_o)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   int          q_rd[$];
   logic [31:0] q_data[$];
   int          m_starve = 0;
   bit          m_stall = 0;
   bit          m_we = 0;
   int          m_rd = 0;
   logic [31:0] m_wdata = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m = '0;
      foreach (q_rd[i]) if (q_rd[i] != 0) m[q_rd[i]] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      q_rd.delete();
      q_data.delete();
      m_starve = 0;
      m_stall  = 0;
      m_we     = 0;
      m_rd     = 0;
      m_wdata  = '0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".we"},    64'(rf_we_o),        64'(m_we));
      check({tag, ".rd"},    64'(rf_rd_o),        64'(m_rd));
      check({tag, ".wdata"}, 64'(rf_wdata_o),     64'(m_wdata));
      check({tag, ".stall"}, 64'(stall_o),        64'(m_stall));
      check({tag, ".mask"},  64'(pending_mask_o), 64'(model_mask()));
   endtask

   // One clock cycle: drive, advance the model by the cycle's rules, then compare after the edge.
   task automatic cycle(input string tag, input bit wbv, input int wrd, input logic [31:0] wd,
                        input bit mcv, input int mrd, input logic [31:0] md);
      bit ready, acc, nonempty, gmc;
      wb_valid_i = wbv;
      wb_rd_i    = ADDR_W'(wrd);
      wb_data_i  = wd;
      mc_valid_i = mcv;
      mc_rd_i    = ADDR_W'(mrd);
      mc_data_i  = md;
      #1;
      ready = (q_rd.size() < FIFO_DEPTH);
      check({tag, ".ready"}, 64'(mc_ready_o), 64'(ready));
      acc      = mcv && ready;
      nonempty = (q_rd.size() > 0);
      gmc      = !wbv && nonempty;
      if (wbv) begin
         m_rd = wrd; m_wdata = wd; m_we = (wrd != 0);
      end else if (gmc) begin
         m_rd = q_rd.pop_front(); m_wdata = q_data.pop_front(); m_we = (m_rd != 0);
      end else begin
         m_we = 0;
      end
      if (!nonempty || gmc) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      if (gmc) m_stall = 0;
      else if (m_starve == STARVE_MAX) m_stall = 1;
      if (acc) begin
         q_rd.push_back(mrd);
         q_data.push_back(md);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst.we", 64'(rf_we_o), 64'd0);
      check("rst.rd", 64'(rf_rd_o), 64'd0);
      check("rst.wdata", 64'(rf_wdata_o), 64'd0);
      check("rst.stall", 64'(stall_o), 64'd0);
      check("rst.mask", 64'(pending_mask_o), 64'd0);
      check("rst.ready", 64'(mc_ready_o), 64'd0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      #1 check("post_rst.ready", 64'(mc_ready_o), 64'd1);

      // Plain pipeline write-back
      cycle("wb", 1, 5, 32'hDEADBEEF, 0, 0, 0);
      check("wb.we_const", 64'(rf_we_o), 64'd1);
      check("wb.rd_const", 64'(rf_rd_o), 64'd5);
      check("wb.data_const", 64'(rf_wdata_o), 64'hDEADBEEF);
      cycle("wb_idle", 0, 0, 0, 0, 0, 0);
      check("wb_idle.we_const", 64'(rf_we_o), 64'd0);
      check("wb_idle.rd_const", 64'(rf_rd_o), 64'd5);

      // Multi-cycle result drained into idle cycle, two-edge latency
      cycle("mc_push", 0, 0, 0, 1, 7, 32'h12);
      check("mc_push.mask7", 64'(pending_mask_o[7]), 64'd1);
      check("mc_push.we_const", 64'(rf_we_o), 64'd0);
      cycle("mc_drain", 0, 0, 0, 0, 0, 0);
      check("mc_drain.we_const", 64'(rf_we_o), 64'd1);
      check("mc_drain.rd_const", 64'(rf_rd_o), 64'd7);
      check("mc_drain.mask7", 64'(pending_mask_o[7]), 64'd0);

      // Starvation under continuous write-back
      cycle("stv_push", 1, 1, 32'h100, 1, 9, 32'h99);
      for (int i = 0; i < 3; i++) cycle("stv_wb", 1, 2, 32'h200 + i, 0, 0, 0);
      check("stv.stall_low", 64'(stall_o), 64'd0);
      cycle("stv_wb4", 1, 2, 32'h300, 0, 0, 0);
      check("stv.stall_high", 64'(stall_o), 64'd1);
      cycle("stv_drain", 0, 0, 0, 0, 0, 0);
      check("stv_drain.rd_const", 64'(rf_rd_o), 64'd9);
      check("stv_drain.stall_const", 64'(stall_o), 64'd0);

      // Full FIFO back-pressure and duplicate destinations
      cycle("full_a", 1, 4, 32'h1, 1, 3, 32'hA);
      cycle("full_b", 1, 4, 32'h2, 1, 3, 32'hB);
      check("full.ready_const", 64'(mc_ready_o), 64'd0);
      cycle("full_c", 1, 4, 32'h3, 1, 3, 32'hC);
      cycle("full_popa", 0, 0, 0, 1, 3, 32'hC);
      check("full_popa.mask3", 64'(pending_mask_o[3]), 64'd1);
      check("full_popa.data_const", 64'(rf_wdata_o), 64'hA);
      cycle("full_popb", 0, 0, 0, 0, 0, 0);
      check("full_popb.mask3", 64'(pending_mask_o[3]), 64'd0);
      check("full_popb.data_const", 64'(rf_wdata_o), 64'hB);

      // Writes to x0
      cycle("x0_a", 1, 0, 32'h55, 1, 0, 32'h66);
      check("x0_a.we_const", 64'(rf_we_o), 64'd0);
      cycle("x0_b", 0, 0, 0, 0, 0, 0);
      check("x0_b.we_const", 64'(rf_we_o), 64'd0);
      check("x0_b.mask_const", 64'(pending_mask_o), 64'd0);

      // Asynchronous reset with buffered entries
      cycle("ar_a", 1, 8, 32'h8, 1, 4, 32'h44);
      cycle("ar_b", 1, 8, 32'h9, 1, 6, 32'h66);
      #3 rst = 1'b1;
      #1;
      check("ar.we", 64'(rf_we_o), 64'd0);
      check("ar.rd", 64'(rf_rd_o), 64'd0);
      check("ar.wdata", 64'(rf_wdata_o), 64'd0);
      check("ar.mask", 64'(pending_mask_o), 64'd0);
      check("ar.ready", 64'(mc_ready_o), 64'd0);
      model_reset();
      wb_valid_i = 1'b0;
      mc_valid_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) cycle("ar_after", 0, 0, 0, 0, 0, 0);

      // Random traffic; the pipeline mostly honours stall_o, occasionally not
      for (int i = 0; i < 400; i++) begin
         bit wbv;
         wbv = ($urandom_range(0, 99) < 55);
         if (m_stall && $urandom_range(0, 9) != 0) wbv = 0;
         cycle("rnd", wbv, $urandom_range(0, 7), $urandom(),
               ($urandom_range(0, 99) < 45), $urandom_range(0, 7), $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
